// File: rtl/usb_tx_packetizer.sv
// USB data-packet transmitter.
// Pulls payload bytes from an upstream byte queue and frames them as a USB
// DATA0/DATA1 packet (PID, payload, CRC-16 low byte, CRC-16 high byte) towards
// a byte serializer using a valid/ready handshake. A data toggle, flipped by
// the host ACK, selects the PID. All outputs come straight from registers.
module usb_tx_packetizer #(
   parameter int MAX_PKT = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           ack,
   input  logic                           fifo_empty,
   output logic                           fifo_rd,
   input  logic [7:0]                     fifo_data,
   output logic [7:0]                     tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic                           tx_last,
   output logic                           busy,
   output logic [$clog2(MAX_PKT+1)-1:0]   byte_count
);

   localparam int              CW        = $clog2(MAX_PKT + 1);
   localparam logic [CW-1:0]   MAX_CNT   = CW'(MAX_PKT);
   localparam logic [7:0]      PID_DATA0 = 8'hC3;
   localparam logic [7:0]      PID_DATA1 = 8'h4B;
   localparam logic [15:0]     CRC_INIT  = 16'hFFFF;
   localparam logic [15:0]     CRC_POLY  = 16'hA001;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PID   = 3'd1,
      S_FETCH = 3'd2,
      S_LOAD  = 3'd3,
      S_DATA  = 3'd4,
      S_CRC_L = 3'd5,
      S_CRC_H = 3'd6
   } state_t;

   // CRC-16/USB byte update: reflected polynomial, data consumed LSB first.
   function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                                input logic [7:0]  data_in);
      logic [15:0] c;
      c = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   state_t          state_r,    state_s;
   logic            toggle_r,   toggle_s;
   logic [CW-1:0]   count_r,    count_s;
   logic [15:0]     crc_r,      crc_s;
   logic [7:0]      hold_r,     hold_s;
   logic [7:0]      tx_data_r,  tx_data_s;
   logic            tx_valid_r, tx_valid_s;
   logic            tx_last_r,  tx_last_s;
   logic            fifo_rd_r,  fifo_rd_s;
   logic            busy_r,     busy_s;
   logic            xfer_s;

   // Next-state, datapath and next-output decode; outputs are derived from
   // the next state so they can be registered without adding latency.
   always_comb begin
      state_s    = state_r;
      toggle_s   = toggle_r;
      count_s    = count_r;
      crc_s      = crc_r;
      hold_s     = hold_r;
      xfer_s     = tx_valid_r & tx_ready;

      case (state_r)
         S_IDLE: begin
            // ack is applied before the PID is chosen, so start+ack together
            // sends the packet with the already-flipped toggle.
            toggle_s = toggle_r ^ ack;
            if (start) begin
               state_s = S_PID;
               count_s = '0;
               crc_s   = CRC_INIT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_PID: begin
            if (xfer_s) begin
               if ((count_r < MAX_CNT) && !fifo_empty) begin
                  state_s = S_FETCH;
               end else begin
                  state_s = S_CRC_L;
               end
            end else begin
               state_s = S_PID;
            end
         end
         S_FETCH: begin
            state_s = S_LOAD;
         end
         S_LOAD: begin
            hold_s  = fifo_data;
            crc_s   = crc16_update(crc_r, fifo_data);
            state_s = S_DATA;
         end
         S_DATA: begin
            if (xfer_s) begin
               // Decide on the post-increment count so the payload stops
               // exactly at MAX_PKT; the leftover bytes stay queued.
               count_s = count_r + CW'(1);
               if ((count_s < MAX_CNT) && !fifo_empty) begin
                  state_s = S_FETCH;
               end else begin
                  state_s = S_CRC_L;
               end
            end else begin
               state_s = S_DATA;
            end
         end
         S_CRC_L: begin
            if (xfer_s) begin
               state_s = S_CRC_H;
            end else begin
               state_s = S_CRC_L;
            end
         end
         S_CRC_H: begin
            if (xfer_s) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_CRC_H;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      tx_data_s  = tx_data_r;
      tx_valid_s = 1'b0;
      tx_last_s  = 1'b0;
      fifo_rd_s  = 1'b0;
      busy_s     = 1'b1;

      case (state_s)
         S_IDLE: begin
            busy_s = 1'b0;
         end
         S_PID: begin
            tx_valid_s = 1'b1;
            if (toggle_s) begin
               tx_data_s = PID_DATA1;
            end else begin
               tx_data_s = PID_DATA0;
            end
         end
         S_FETCH: begin
            fifo_rd_s = 1'b1;
         end
         S_LOAD: begin
            tx_data_s = tx_data_r;
         end
         S_DATA: begin
            tx_valid_s = 1'b1;
            tx_data_s  = hold_s;
         end
         S_CRC_L: begin
            tx_valid_s = 1'b1;
            tx_data_s  = ~crc_s[7:0];
         end
         S_CRC_H: begin
            tx_valid_s = 1'b1;
            tx_last_s  = 1'b1;
            tx_data_s  = ~crc_s[15:8];
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset wins over every input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         toggle_r   <= 1'b0;
         count_r    <= '0;
         crc_r      <= 16'h0000;
         hold_r     <= 8'h00;
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
         tx_last_r  <= 1'b0;
         fifo_rd_r  <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         toggle_r   <= toggle_s;
         count_r    <= count_s;
         crc_r      <= crc_s;
         hold_r     <= hold_s;
         tx_data_r  <= tx_data_s;
         tx_valid_r <= tx_valid_s;
         tx_last_r  <= tx_last_s;
         fifo_rd_r  <= fifo_rd_s;
         busy_r     <= busy_s;
      end
   end

   assign tx_data    = tx_data_r;
   assign tx_valid   = tx_valid_r;
   assign tx_last    = tx_last_r;
   assign fifo_rd    = fifo_rd_r;
   assign busy       = busy_r;
   assign byte_count = count_r;

endmodule
